ahblite_master_arbiter: RTL and testbench

Two-master AHB-Lite arbiter placed between the bus masters (M0 = CPU, M1 = DMA) and the address decoder / slave response mux. It shares the single AHB-Lite slave path between both masters. Each master gets a one-entry address holding stage, so either master can issue a transfer at any time. Arbitration is round-robin, with the grant locked for the duration of fixed-length bursts.

---
 rtl/ahblite_master_arbiter_if.sv | 41 ++++
 rtl/ahblite_master_arbiter.sv | 112 +++++++++++
 tb/tb_ahblite_master_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahblite_master_arbiter_if.sv
// Bus bundle around the two-master AHB-Lite arbiter: per-master request side
// (packed [master] arrays) plus the single shared slave path.
interface ahblite_master_arbiter_if;
  logic [1:0][31:0] M_HADDR;
  logic [1:0][1:0]  M_HTRANS;
  logic [1:0]       M_HWRITE;
  logic [1:0][2:0]  M_HSIZE;
  logic [1:0][2:0]  M_HBURST;
  logic [1:0][3:0]  M_HPROT;
  logic [1:0][31:0] M_HWDATA;
  logic [1:0]       M_HREADY;
  logic [1:0]       M_HRESP;
  logic [1:0][31:0] M_HRDATA;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  // master: the arbiter, which masters the shared slave path
  modport master (
    input  M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT, M_HWDATA,
    input  HREADY, HRESP, HRDATA,
    output M_HREADY, M_HRESP, M_HRDATA,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );

  // slave: the environment (bus masters plus decoder / response mux)
  modport slave (
    output M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT, M_HWDATA,
    output HREADY, HRESP, HRDATA,
    input  M_HREADY, M_HRESP, M_HRDATA,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );
endinterface

// File: rtl/ahblite_master_arbiter.sv
// Two-master AHB-Lite arbiter: one-entry address holding stage per master,
// round-robin grant, grant locked across fixed-length bursts.
module ahblite_master_arbiter #(
  parameter logic PARK = 1'b0
) (
  input logic                      HCLK,
  input logic                      HRESETn,
  ahblite_master_arbiter_if.master io_bus
);
  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
  } ap_t;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

  logic            r_addr_owner, r_last_grant, r_last_acc_owner;
  logic            r_dph_valid, r_dph_owner;
  logic [1:0]      r_pend;
  ap_t  [1:0]      r_cap;
  logic [3:0]      r_beats_left;

  ap_t  [1:0]      w_live, w_src;
  logic [1:0]      w_req, w_mready, w_issue, w_cap;
  ap_t             w_bus;
  logic [3:0]      w_beats_nxt;
  logic            w_any_req, w_winner;

  always_comb begin
    for (int x = 0; x < 2; x++) begin
      w_live[x] = {io_bus.M_HADDR[x], io_bus.M_HTRANS[x], io_bus.M_HWRITE[x],
                   io_bus.M_HSIZE[x], io_bus.M_HBURST[x], io_bus.M_HPROT[x]};
      w_req[x]  = r_pend[x] | w_live[x].htrans[1];
      w_src[x]  = r_pend[x] ? r_cap[x] : w_live[x];
      // a held SEQ lost its burst context if someone else used the bus meanwhile
      if (r_pend[x] && r_cap[x].htrans == SEQ && r_last_acc_owner != x[0])
        w_src[x].htrans = NONSEQ;
      w_mready[x] = r_pend[x] ? 1'b0 :
                    (r_dph_valid && r_dph_owner == x[0]) ? io_bus.HREADY : 1'b1;
      w_issue[x]  = (r_addr_owner == x[0]) && io_bus.HREADY;
      w_cap[x]    = w_mready[x] && !r_pend[x] && w_live[x].htrans[1] && !w_issue[x];
    end

    w_bus = w_src[r_addr_owner];
    if (!w_req[r_addr_owner]) w_bus.htrans = IDLE;

    w_beats_nxt = r_beats_left;
    if (io_bus.HREADY) begin
      if (w_bus.htrans == NONSEQ) begin
        case (w_bus.hburst)
          3'd2, 3'd3: w_beats_nxt = 4'd3;
          3'd4, 3'd5: w_beats_nxt = 4'd7;
          3'd6, 3'd7: w_beats_nxt = 4'd15;
          default:    w_beats_nxt = 4'd0;
        endcase
      end else if (w_bus.htrans == SEQ && r_beats_left != 4'd0) begin
        w_beats_nxt = r_beats_left - 4'd1;
      end
    end

    w_any_req = |w_req;
    w_winner  = (&w_req) ? ~r_last_grant : w_req[1];
  end

  assign io_bus.HADDR    = w_bus.haddr;
  assign io_bus.HTRANS   = w_bus.htrans;
  assign io_bus.HWRITE   = w_bus.hwrite;
  assign io_bus.HSIZE    = w_bus.hsize;
  assign io_bus.HBURST   = w_bus.hburst;
  assign io_bus.HPROT    = w_bus.hprot;
  assign io_bus.HWDATA   = io_bus.M_HWDATA[r_dph_owner];
  assign io_bus.M_HREADY = w_mready;
  assign io_bus.M_HRESP  = {2{io_bus.HRESP & r_dph_valid}} & {r_dph_owner, ~r_dph_owner};
  assign io_bus.M_HRDATA = {2{io_bus.HRDATA}};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr_owner     <= PARK;
      r_last_grant     <= PARK;
      r_last_acc_owner <= PARK;
      r_dph_valid      <= 1'b0;
      r_dph_owner      <= 1'b0;
      r_pend           <= '0;
      r_cap            <= '0;
      r_beats_left     <= '0;
    end else begin
      for (int x = 0; x < 2; x++) begin
        if (w_cap[x]) begin
          r_pend[x] <= 1'b1;
          r_cap[x]  <= w_live[x];
        end else if (r_pend[x] && w_issue[x]) begin
          r_pend[x] <= 1'b0;
        end
      end
      r_beats_left <= w_beats_nxt;
      if (io_bus.HREADY) begin
        r_dph_valid <= w_bus.htrans[1];
        r_dph_owner <= r_addr_owner;
        if (w_bus.htrans[1]) r_last_acc_owner <= r_addr_owner;
        // re-arbitrate only once any fixed-length burst has fully issued
        if (w_beats_nxt == 4'd0) begin
          r_addr_owner <= w_any_req ? w_winner : PARK;
          if (w_any_req) r_last_grant <= w_winner;
        end
      end
    end
  end
endmodule

// File: tb/tb_ahblite_master_arbiter.sv
// Randomized bench for ahblite_master_arbiter against a transaction-level
// reference model (held requests kept in an associative array).
module tb_ahblite_master_arbiter;
  localparam logic PARK = 1'b0;
  localparam logic [1:0] NS = 2'b10, SQ = 2'b11;

  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
  } ap_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  ahblite_master_arbiter_if bus();
  ahblite_master_arbiter #(.PARK(PARK)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .io_bus(bus));
  always #5 HCLK = ~HCLK;

  int n_chk = 0, n_err = 0;
  int blen [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  // reference model state
  ap_t  held [int];
  int   m_own, m_lastg, m_lastacc, m_do, m_left;
  bit   m_dv;
  ap_t  e_live [2];
  ap_t  e_bus;
  bit [1:0] e_req, e_mrdy, e_mresp;
  logic [31:0] e_wdata, rd_v;
  ap_t idle_ap = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic ap_t mk(logic [31:0] a, logic [1:0] t, logic w, logic [2:0] b);
    mk = {a, t, w, 3'd2, b, 4'd3};
  endfunction

  function automatic ap_t rnd_ap();
    int r;
    logic [1:0] t;
    r = $urandom_range(0, 99);
    t = (r < 40) ? 2'b00 : (r < 70) ? NS : (r < 95) ? SQ : 2'b01;
    rnd_ap = {32'h1000 + 32'($urandom_range(0, 255) << 2), t, 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
  endfunction

  task automatic model_reset();
    held.delete();
    m_own = PARK; m_lastg = PARK; m_lastacc = PARK; m_do = 0; m_left = 0; m_dv = 0;
  endtask

  task automatic model_eval();
    ap_t src [2];
    for (int x = 0; x < 2; x++) begin
      e_live[x] = {bus.M_HADDR[x], bus.M_HTRANS[x], bus.M_HWRITE[x],
                   bus.M_HSIZE[x], bus.M_HBURST[x], bus.M_HPROT[x]};
      e_req[x]  = held.exists(x) || e_live[x].htrans[1];
      src[x]    = held.exists(x) ? held[x] : e_live[x];
      if (held.exists(x) && src[x].htrans == SQ && m_lastacc != x) src[x].htrans = NS;
      e_mrdy[x]  = held.exists(x) ? 1'b0 : (m_dv && m_do == x) ? bus.HREADY : 1'b1;
      e_mresp[x] = m_dv && m_do == x && bus.HRESP;
    end
    e_bus = src[m_own];
    if (!e_req[m_own]) e_bus.htrans = 2'b00;
    e_wdata = bus.M_HWDATA[m_do];
  endtask

  task automatic model_update();
    bit hr;
    hr = bus.HREADY;
    for (int x = 0; x < 2; x++) begin
      if (held.exists(x)) begin
        if (m_own == x && hr) held.delete(x);
      end else if (e_mrdy[x] && e_live[x].htrans[1] && !(m_own == x && hr)) begin
        held[x] = e_live[x];
      end
    end
    if (hr) begin
      m_dv = e_bus.htrans[1];
      m_do = m_own;
      if (m_dv) m_lastacc = m_own;
      if (e_bus.htrans == NS) m_left = blen[e_bus.hburst] - 1;
      else if (e_bus.htrans == SQ && m_left > 0) m_left--;
      if (m_left == 0) begin
        if (e_req == 2'b11) m_own = 1 - m_lastg;
        else if (e_req[0]) m_own = 0;
        else if (e_req[1]) m_own = 1;
        else m_own = PARK;
        if (e_req != 2'b00) m_lastg = m_own;
      end
    end
  endtask

  task automatic set_in(input ap_t a0, input ap_t a1, input bit rdy, input bit resp);
    {bus.M_HADDR[0], bus.M_HTRANS[0], bus.M_HWRITE[0], bus.M_HSIZE[0], bus.M_HBURST[0], bus.M_HPROT[0]} = a0;
    {bus.M_HADDR[1], bus.M_HTRANS[1], bus.M_HWRITE[1], bus.M_HSIZE[1], bus.M_HBURST[1], bus.M_HPROT[1]} = a1;
    bus.M_HWDATA[0] = $urandom;
    bus.M_HWDATA[1] = $urandom;
    rd_v        = $urandom;
    bus.HRDATA  = rd_v;
    bus.HREADY  = rdy;
    bus.HRESP   = resp;
  endtask

  task automatic compare();
    chk("haddr", bus.HADDR, e_bus.haddr);
    chk("htrans", bus.HTRANS, e_bus.htrans);
    chk("hctl", {bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT},
                {e_bus.hwrite, e_bus.hsize, e_bus.hburst, e_bus.hprot});
    chk("hwdata", bus.HWDATA, e_wdata);
    chk("m_hready", bus.M_HREADY, e_mrdy);
    chk("m_hresp", bus.M_HRESP, e_mresp);
    chk("m_hrdata", bus.M_HRDATA, {rd_v, rd_v});
    for (int x = 0; x < 2; x++)
      chk("pend_vs_dph", dut.r_pend[x] & dut.r_dph_valid & (dut.r_dph_owner == x[0]), 1'b0);
  endtask

  task automatic drive(input ap_t a0, input ap_t a1, input bit rdy, input bit resp);
    @(negedge HCLK);
    set_in(a0, a1, rdy, resp);
    #1;
    model_eval();
    compare();
  endtask

  task automatic step();
    @(posedge HCLK);
    model_update();
  endtask

  task automatic cyc(input ap_t a0, input ap_t a1, input bit rdy, input bit resp);
    drive(a0, a1, rdy, resp);
    step();
  endtask

  initial begin
    model_reset();
    set_in(idle_ap, idle_ap, 1'b1, 1'b1);
    #6;
    chk("rst_htrans", bus.HTRANS, 2'b00);
    chk("rst_mrdy", bus.M_HREADY, 2'b11);
    chk("rst_mresp", bus.M_HRESP, 2'b00);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // M0 single read, zero wait: address on the bus in the same cycle
    drive(mk(32'h10, NS, 1'b0, 3'd0), idle_ap, 1'b1, 1'b0);
    chk("t1_haddr", bus.HADDR, 32'h10);
    chk("t1_m1rdy", bus.M_HREADY[1], 1'b1);
    step();
    drive(idle_ap, idle_ap, 1'b1, 1'b0);
    chk("t1_m0rdy", bus.M_HREADY[0], 1'b1);
    chk("t1_rdata", bus.M_HRDATA[0], rd_v);
    step();
    cyc(idle_ap, idle_ap, 1'b1, 1'b0);

    // M0 INCR4 write, M1 arrives at beat 2 and waits out the burst
    drive(mk(32'h100, NS, 1'b1, 3'd3), idle_ap, 1'b1, 1'b0);
    chk("b_a0", bus.HADDR, 32'h100); step();
    drive(mk(32'h104, SQ, 1'b1, 3'd3), mk(32'h200, NS, 1'b0, 3'd0), 1'b1, 1'b0);
    chk("b_a1", bus.HADDR, 32'h104); step();
    drive(mk(32'h108, SQ, 1'b1, 3'd3), idle_ap, 1'b1, 1'b0);
    chk("b_a2", bus.HADDR, 32'h108);
    chk("b_m1wait", bus.M_HREADY[1], 1'b0); step();
    drive(mk(32'h10C, SQ, 1'b1, 3'd3), idle_ap, 1'b1, 1'b0);
    chk("b_a3", bus.HADDR, 32'h10C); step();
    drive(idle_ap, idle_ap, 1'b1, 1'b0);
    chk("b_m1addr", bus.HADDR, 32'h200);
    chk("b_m1trans", bus.HTRANS, NS); step();
    drive(idle_ap, idle_ap, 1'b1, 1'b0);
    chk("b_m1done", bus.M_HREADY[1], 1'b1); step();
    cyc(idle_ap, idle_ap, 1'b1, 1'b0);

    // M1 undefined INCR interrupted by M0: held SEQ reissued as NONSEQ
    cyc(idle_ap, mk(32'h300, NS, 1'b0, 3'd1), 1'b1, 1'b0);
    drive(mk(32'h400, NS, 1'b0, 3'd0), mk(32'h304, SQ, 1'b0, 3'd1), 1'b1, 1'b0);
    chk("h_m1first", bus.HADDR, 32'h300); step();
    drive(idle_ap, mk(32'h304, SQ, 1'b0, 3'd1), 1'b1, 1'b0);
    chk("h_m0", bus.HADDR, 32'h400); step();
    drive(idle_ap, idle_ap, 1'b1, 1'b0);
    chk("h_seq_addr", bus.HADDR, 32'h304);
    chk("h_seq_ns", bus.HTRANS, NS); step();

    // random traffic with wait states and error responses
    for (int i = 0; i < 3000; i++)
      cyc(rnd_ap(), rnd_ap(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);

    // reset in the middle of a burst with a request held
    cyc(mk(32'h500, NS, 1'b1, 3'd5), idle_ap, 1'b1, 1'b0);
    cyc(mk(32'h504, SQ, 1'b1, 3'd5), mk(32'h600, NS, 1'b0, 3'd0), 1'b1, 1'b0);
    @(negedge HCLK);
    set_in(idle_ap, idle_ap, 1'b1, 1'b1);
    HRESETn = 1'b0;
    #1;
    chk("rst2_htrans", bus.HTRANS, 2'b00);
    chk("rst2_mrdy", bus.M_HREADY, 2'b11);
    chk("rst2_mresp", bus.M_HRESP, 2'b00);
    model_reset();
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(idle_ap, idle_ap, 1'b1, 1'b0);
      chk("no_replay", bus.HTRANS, 2'b00);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
